guard_insert: RTL and testbench
===============================

Name: guard_insert

Overview:
- AXI4-Stream sample-path block in the OFDM transmit chain, placed after cyclic-prefix insertion and before the DAC/output path.
- Forwards each segment of complex samples unchanged: the preamble, then each CP+OFDM symbol.
- After every segment it inserts a run-time programmable number of zero-valued guard samples, back-pressuring the input while it does so.

Parameters:
- g_ILA, 0: when 1, instantiate debug probes on the state and counters; no functional effect.
- g_PREAMBLE_LEN, 4096: body length of the first segment of each frame, in samples.

Ports:
- aclk, input, 1: single clock; all logic is rising-edge.
- areset, input, 1: synchronous, active-high reset.
- s_axis_tdata, input, 32: input sample, I/Q packed 16/16; treated as opaque.
- s_axis_tvalid, input, 1: input valid.
- s_axis_tlast, input, 1: marks the last sample of a frame.
- s_axis_tready, output, 1: input ready.
- m_axis_tdata, output, 32: output sample, or 0 during guard.
- m_axis_tvalid, output, 1: output valid.
- m_axis_tlast, output, 1: end of frame on the output.
- m_axis_tready, input, 1: output ready.
- i_guard_cycles, input, 32: guard samples inserted after each segment; 0 means no guard.
- i_nfft, input, 14: FFT size minus 1.
- i_cp_len, input, 12: CP length minus 1; 0 means no CP.

Behaviour:
- Reset (synchronous, active-high) clears the following:
  - m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, s_axis_tready=0.
  - All counters=0; state=PRE.
  - Reset mid-frame abandons the frame; the next accepted sample is treated as preamble sample 0.
- Segment lengths, computed in 16-bit unsigned:
  - CP term = 0 if i_cp_len==0, else i_cp_len+1.
  - Preamble segment = g_PREAMBLE_LEN + CP term.
  - Symbol segment = (i_nfft+1) + CP term.
- Configuration inputs are sampled at the first accepted sample of each segment. They must be held stable within a frame.
- Output register:
  - Registered output stage; latency is 1 cycle from input transfer to m_axis_tvalid.
  - Output holds while m_axis_tvalid=1 and m_axis_tready=0.
  - The register may load when it is empty or m_axis_tready=1.
- s_axis_tready = (state is PRE or SYM) AND (output register may load).
- States:
  - PRE: pass preamble samples and count transfers. When the count reaches preamble segment length, go to GUARD (or SYM if i_guard_cycles==0).
  - SYM: pass samples. When the count reaches symbol segment length, go to GUARD (or stay in SYM with count cleared if i_guard_cycles==0).
  - GUARD: s_axis_tready=0. Emit i_guard_cycles beats of tdata=0, tvalid=1, advancing only on output acceptance. Then return to SYM, or to PRE if the segment just closed carried tlast.
- tlast handling:
  - An input tlast ends the segment immediately, even if the segment count is incomplete.
  - The frame restarts with a preamble next.
  - m_axis_tlast is asserted only on the final output beat of the frame: the last guard sample, or the tlast data sample itself if i_guard_cycles==0.
  - Data samples forward tlast=0 except in that case.
- Input tvalid low inside a segment: no count advance, no output bubble penalty beyond the idle cycle, and no guard insertion.
- If a segment count and tlast coincide, the segment closes once; no double guard.
- i_guard_cycles is a 32-bit counter; no wrap within the supported range.

Decomposition:
- Shared package guard_insert_pkg holds:
  - state enum (PRE, SYM, GUARD);
  - AXIS data width constant 32;
  - segment counter width 16.
- One natural sub-module: axis_out_reg, the output register/handshake stage. The control FSM stays in guard_insert.

Test Plan:
1. nfft=31, cp_len=4, guard=10, m_tready=1 continuously:
   - Stimulus: 4101 preamble samples, then two 37-sample symbols, tlast on the final one.
   - Required output: 4101 data, 10 zeros, 37 data, 10 zeros, 37 data, 10 zeros. Total 4205 beats; m_tlast only on beat 4205; s_tready low exactly during each guard run.
2. cp_len=0, same stream with 32-sample symbols:
   - Required: preamble segment 4096 samples; symbol segment 32; guards inserted after each.
3. guard=0:
   - Required: output identical to input with 1-cycle latency and no ready gaps.
   - m_tlast coincides with the input tlast sample.
4. m_tready toggled 50% during a guard run:
   - Required: exactly 10 zero beats still emitted; no data lost or duplicated; input stalled until guard done.
5. Early tlast on sample 20 of a 37-sample symbol:
   - Required: guard of 10 follows, m_tlast on its last beat.
   - The next frame's first 4101 samples are treated as preamble.
6. areset asserted mid-symbol:
   - Required: outputs clear on the next edge.
   - After release, the first segment is 4101 samples long.

Source files
------------

// File: rtl/guard_insert_pkg.sv
// Shared types and constants for the guard-interval insertion block.
package guard_insert_pkg;

   localparam int AXIS_W = 32;
   localparam int CNT_W  = 16;

   typedef enum logic [1:0] {
      PRE   = 2'd0,
      SYM   = 2'd1,
      GUARD = 2'd2
   } state_t;

   // Segment length in samples: body (preamble or FFT size) plus optional CP.
   function automatic logic [CNT_W-1:0] seg_len(
      input logic             is_pre,
      input logic [CNT_W-1:0] pre_len,
      input logic [13:0]      nfft,
      input logic [11:0]      cp_len
   );
      logic [CNT_W-1:0] cp_term;
      logic [CNT_W-1:0] body;
      cp_term = (cp_len == 12'd0) ? 16'd0 : ({4'd0, cp_len} + 16'd1);
      body    = is_pre ? pre_len : ({2'd0, nfft} + 16'd1);
      return body + cp_term;
   endfunction

endpackage

// File: rtl/guard_insert_if.sv
// AXI4-Stream sample bus used on both sides of the guard inserter.
interface guard_insert_if;
   import guard_insert_pkg::*;

   logic [AXIS_W-1:0] tdata;
   logic              tvalid;
   logic              tlast;
   logic              tready;

   modport master (output tdata, output tvalid, output tlast, input tready);
   modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/guard_insert_axis_out_reg.sv
// Single-entry registered AXI4-Stream output stage. Loads whenever it is
// empty or its current beat is being accepted downstream.
module axis_out_reg
   import guard_insert_pkg::*;
(
   input  logic              aclk,
   input  logic              areset,
   input  logic              load_valid,
   input  logic [AXIS_W-1:0] load_data,
   input  logic              load_last,
   output logic              may_load,
   guard_insert_if.master    m_axis
);

   logic [AXIS_W-1:0] tdata_r;
   logic              tvalid_r;
   logic              tlast_r;
   logic              may_load_s;

   assign may_load_s = ~tvalid_r | m_axis.tready;
   assign may_load   = may_load_s;

   assign m_axis.tdata  = tdata_r;
   assign m_axis.tvalid = tvalid_r;
   assign m_axis.tlast  = tlast_r;

   // Output register: take a new beat (or a bubble) when the slot is free.
   always_ff @(posedge aclk) begin
      if (areset) begin
         tdata_r  <= {AXIS_W{1'b0}};
         tvalid_r <= 1'b0;
         tlast_r  <= 1'b0;
      end else if (may_load_s) begin
         tvalid_r <= load_valid;
         tlast_r  <= load_valid & load_last;
         if (load_valid) begin
            tdata_r <= load_data;
         end else begin
            tdata_r <= tdata_r;
         end
      end else begin
         tdata_r  <= tdata_r;
         tvalid_r <= tvalid_r;
         tlast_r  <= tlast_r;
      end
   end

endmodule

// File: rtl/guard_insert.sv
// Guard-interval inserter: forwards preamble and CP+symbol segments and
// appends a programmable run of zero samples after each one.
module guard_insert
   import guard_insert_pkg::*;
#(
   parameter int g_ILA          = 0,
   parameter int g_PREAMBLE_LEN = 4096
) (
   input  logic           aclk,
   input  logic           areset,
   guard_insert_if.slave  s_axis,
   guard_insert_if.master m_axis,
   input  logic [31:0]    i_guard_cycles,
   input  logic [13:0]    i_nfft,
   input  logic [11:0]    i_cp_len
);

   localparam logic [CNT_W-1:0] PRE_LEN_C = CNT_W'(g_PREAMBLE_LEN);

   state_t            state_r;
   logic [CNT_W-1:0]  seg_cnt_r;
   logic [CNT_W-1:0]  seg_len_r;
   logic [31:0]       guard_len_r;
   logic [31:0]       guard_cnt_r;
   logic              frame_end_r;

   logic              may_load_s;
   logic              pass_s;
   logic              s_ready_s;
   logic              in_xfer_s;
   logic              first_s;
   logic [CNT_W-1:0]  cur_len_s;
   logic [31:0]       cur_guard_s;
   logic [CNT_W-1:0]  cnt_inc_s;
   logic              seg_done_s;
   logic              guard_done_s;
   logic              load_valid_s;
   logic [AXIS_W-1:0] load_data_s;
   logic              load_last_s;

   assign pass_s       = (state_r == PRE) | (state_r == SYM);
   assign s_ready_s    = ~areset & pass_s & may_load_s;
   assign s_axis.tready = s_ready_s;
   assign in_xfer_s    = s_ready_s & s_axis.tvalid;

   // Configuration is captured on the first transfer of a segment; until
   // then the live inputs stand in for the latched copies.
   assign first_s      = (seg_cnt_r == 16'd0);
   assign cnt_inc_s    = seg_cnt_r + 16'd1;
   assign guard_done_s = ((guard_cnt_r + 32'd1) == guard_len_r);

   // Segment bookkeeping and the beat presented to the output register.
   always_comb begin
      cur_len_s    = seg_len_r;
      cur_guard_s  = guard_len_r;
      seg_done_s   = 1'b0;
      load_valid_s = 1'b0;
      load_data_s  = {AXIS_W{1'b0}};
      load_last_s  = 1'b0;
      if (first_s) begin
         cur_len_s   = seg_len(state_r == PRE, PRE_LEN_C, i_nfft, i_cp_len);
         cur_guard_s = i_guard_cycles;
      end else begin
         cur_len_s   = seg_len_r;
         cur_guard_s = guard_len_r;
      end
      seg_done_s = (cnt_inc_s == cur_len_s) | s_axis.tlast;
      if (state_r == GUARD) begin
         load_valid_s = may_load_s;
         load_data_s  = {AXIS_W{1'b0}};
         load_last_s  = frame_end_r & guard_done_s;
      end else begin
         load_valid_s = in_xfer_s;
         load_data_s  = s_axis.tdata;
         load_last_s  = s_axis.tlast & (cur_guard_s == 32'd0);
      end
   end

   // Control FSM: count segment transfers, then run the guard interval.
   always_ff @(posedge aclk) begin
      if (areset) begin
         state_r     <= PRE;
         seg_cnt_r   <= 16'd0;
         seg_len_r   <= 16'd0;
         guard_len_r <= 32'd0;
         guard_cnt_r <= 32'd0;
         frame_end_r <= 1'b0;
      end else begin
         case (state_r)
            PRE, SYM: begin
               if (in_xfer_s) begin
                  if (first_s) begin
                     seg_len_r   <= cur_len_s;
                     guard_len_r <= i_guard_cycles;
                  end
                  if (seg_done_s) begin
                     seg_cnt_r   <= 16'd0;
                     guard_cnt_r <= 32'd0;
                     frame_end_r <= s_axis.tlast;
                     if (cur_guard_s == 32'd0) begin
                        state_r <= s_axis.tlast ? PRE : SYM;
                     end else begin
                        state_r <= GUARD;
                     end
                  end else begin
                     seg_cnt_r <= cnt_inc_s;
                  end
               end
            end
            GUARD: begin
               if (may_load_s) begin
                  if (guard_done_s) begin
                     guard_cnt_r <= 32'd0;
                     state_r     <= frame_end_r ? PRE : SYM;
                  end else begin
                     guard_cnt_r <= guard_cnt_r + 32'd1;
                  end
               end
            end
            default: begin
               state_r <= PRE;
            end
         endcase
      end
   end

   axis_out_reg u_out_reg (
      .aclk       (aclk),
      .areset     (areset),
      .load_valid (load_valid_s),
      .load_data  (load_data_s),
      .load_last  (load_last_s),
      .may_load   (may_load_s),
      .m_axis     (m_axis)
   );

   generate
      if (g_ILA != 0) begin : g_ila
         (* mark_debug = "true" *) logic [1:0]       ila_state_r;
         (* mark_debug = "true" *) logic [CNT_W-1:0] ila_seg_cnt_r;
         (* mark_debug = "true" *) logic [31:0]      ila_guard_cnt_r;

         // Debug probe capture of the control state and counters.
         always_ff @(posedge aclk) begin
            ila_state_r     <= state_r;
            ila_seg_cnt_r   <= seg_cnt_r;
            ila_guard_cnt_r <= guard_cnt_r;
         end
      end
   endgenerate

endmodule

// File: tb/tb_guard_insert.sv
// Self-checking bench for guard_insert: random samples through a frame-level
// reference model, compared beat by beat on the output.
module tb_guard_insert;

   localparam int PRE_BODY = 4096;

   typedef struct {
      logic [31:0] data;
      logic        last;
      bit          guard;
      bit          run_last;
   } beat_t;

   logic        clk;
   logic        areset;
   logic [31:0] cfg_guard;
   logic [13:0] cfg_nfft;
   logic [11:0] cfg_cp;

   guard_insert_if s_if ();
   guard_insert_if m_if ();

   guard_insert dut (
      .aclk           (clk),
      .areset         (areset),
      .s_axis         (s_if),
      .m_axis         (m_if),
      .i_guard_cycles (cfg_guard),
      .i_nfft         (cfg_nfft),
      .i_cp_len       (cfg_cp)
   );

   int    vectors     = 0;
   int    miscompares = 0;
   int    cyc         = 0;
   int    acc_cyc     = 0;
   int    last_cyc    = 0;
   bit    first_mark  = 0;
   bit    mon_off     = 1;
   bit    rand_rdy    = 0;
   beat_t exp_q[$];
   beat_t mon_b;
   int    mdl_cnt     = 0;
   bit    mdl_pre     = 1;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model: one accepted input sample -> expected output beats.
   task automatic model_push(input logic [31:0] d, input logic l);
      int seglen;
      exp_q.push_back('{d, l && (cfg_guard == 0), 1'b0, 1'b0});
      mdl_cnt++;
      seglen = (mdl_pre ? PRE_BODY : int'(cfg_nfft) + 1) + ((cfg_cp == 0) ? 0 : int'(cfg_cp) + 1);
      if (mdl_cnt == seglen || l) begin
         for (int k = 0; k < int'(cfg_guard); k++)
            exp_q.push_back('{32'd0, l && (k == int'(cfg_guard) - 1), 1'b1, k == int'(cfg_guard) - 1});
         mdl_cnt = 0;
         mdl_pre = l;
      end
   endtask

   initial begin
      m_if.tready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         m_if.tready = rand_rdy ? 1'($urandom_range(1)) : 1'b1;
      end
   end

   // Output monitor: every accepted beat must match the model's next beat.
   always @(negedge clk) begin
      if (!mon_off && m_if.tvalid === 1'b1 && m_if.tready === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_beat", 32'(exp_q.size()), 32'd1);
         end else begin
            mon_b = exp_q.pop_front();
            check("m_tdata", m_if.tdata, mon_b.data);
            check("m_tlast", {31'd0, m_if.tlast}, {31'd0, mon_b.last});
            if (mon_b.guard && !mon_b.run_last)
               check("s_tready_in_guard", {31'd0, s_if.tready}, 32'd0);
            if (mon_b.last) last_cyc = cyc;
         end
      end
   end

   task automatic send(input logic [31:0] d, input logic l, input int gap_pct, input bit chk_rdy);
      int n;
      if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
         s_if.tvalid = 1'b0;
         @(posedge clk);
         #1;
      end
      s_if.tdata  = d;
      s_if.tlast  = l;
      s_if.tvalid = 1'b1;
      n = 0;
      @(negedge clk);
      while (s_if.tready !== 1'b1 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (chk_rdy) check("ready_gap", 32'(n), 32'd0);
      if (n >= 1000) check("send_timeout", 32'(n), 32'd0);
      if (first_mark) begin
         acc_cyc    = cyc + 1;
         first_mark = 0;
      end
      @(posedge clk);
      #1;
      s_if.tvalid = 1'b0;
      s_if.tlast  = 1'b0;
      model_push(d, l);
   endtask

   task automatic send_seg(input int n, input bit last_on_final, input int gap_pct, input bit chk_rdy);
      for (int i = 0; i < n; i++)
         send($urandom, last_on_final && (i == n - 1), gap_pct, chk_rdy);
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 20000) begin
         @(negedge clk);
         n++;
      end
      check("drain", 32'(exp_q.size()), 32'd0);
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      areset      = 1'b1;
      s_if.tdata  = 32'd0;
      s_if.tvalid = 1'b0;
      s_if.tlast  = 1'b0;
      cfg_guard   = 32'd10;
      cfg_nfft    = 14'd31;
      cfg_cp      = 12'd4;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_m_tvalid", {31'd0, m_if.tvalid}, 32'd0);
      check("rst_m_tlast",  {31'd0, m_if.tlast},  32'd0);
      check("rst_m_tdata",  m_if.tdata,           32'd0);
      check("rst_s_tready", {31'd0, s_if.tready}, 32'd0);
      @(posedge clk);
      #1;
      areset  = 1'b0;
      mon_off = 0;

      // 1: preamble + two 37-sample symbols, continuous flow
      first_mark = 1;
      send_seg(4101, 0, 0, 0);
      send_seg(37, 0, 0, 0);
      send_seg(37, 1, 0, 0);
      wait_drain();
      check("t1_span", 32'(last_cyc - acc_cyc), 32'd4204);

      // 2: no CP, 32-sample symbols, random input gaps
      cfg_cp = 12'd0;
      send_seg(4096, 0, 15, 0);
      send_seg(32, 0, 15, 0);
      send_seg(32, 1, 15, 0);
      wait_drain();

      // 3: no guard, pass-through with no ready gaps
      cfg_cp     = 12'd4;
      cfg_guard  = 32'd0;
      first_mark = 1;
      send_seg(4101, 0, 0, 1);
      send_seg(37, 0, 0, 1);
      send_seg(37, 1, 0, 1);
      wait_drain();
      check("t3_span", 32'(last_cyc - acc_cyc), 32'd4174);

      // 4: random downstream back-pressure through guard runs
      cfg_guard = 32'd10;
      rand_rdy  = 1;
      send_seg(4101, 0, 0, 0);
      send_seg(37, 1, 0, 0);
      wait_drain();
      rand_rdy = 0;

      // 5: early tlast on sample 20, then a full frame follows
      send_seg(4101, 0, 10, 0);
      send_seg(20, 1, 10, 0);
      send_seg(4101, 0, 10, 0);
      send_seg(37, 1, 10, 0);
      wait_drain();

      // 6: reset in the middle of a symbol
      send_seg(4101, 0, 0, 0);
      send_seg(15, 0, 0, 0);
      mon_off = 1;
      areset  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("mid_rst_m_tvalid", {31'd0, m_if.tvalid}, 32'd0);
      check("mid_rst_m_tlast",  {31'd0, m_if.tlast},  32'd0);
      check("mid_rst_m_tdata",  m_if.tdata,           32'd0);
      check("mid_rst_s_tready", {31'd0, s_if.tready}, 32'd0);
      exp_q.delete();
      mdl_cnt = 0;
      mdl_pre = 1;
      @(posedge clk);
      #1;
      areset  = 1'b0;
      mon_off = 0;
      send_seg(4101, 0, 0, 0);
      send_seg(37, 1, 0, 0);
      wait_drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
